key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
//   Conditions raw push-button inputs before they reach the counter/display stages.
//   Per key: 2-FF synchronizer, debounce FSM, clean held level, one-cycle press and
//   release pulses, and an optional auto-repeat pulse while the key is held.
//   Sits directly upstream of the counter block and replaces its ad-hoc edge detect.
// PARAMETERS
//   KEYS              2          number of independent keys
//   DEBOUNCE_CYC      1000000    cycles input must be stable (10 ms @ 100 MHz), >=1
//   REPEAT_DELAY_CYC  50000000   HELD cycles before first repeat pulse; 0 = repeat off
//   REPEAT_RATE_CYC   10000000   cycles between subsequent repeat pulses, >=1
//   ACTIVE_LOW        1          1: raw key reads 0 when pressed (board keys)
// PORTS
//   clk100_i       in   1     100 MHz system clock
//   rstn_i         in   1     synchronous reset, active-low
//   key_i          in   KEYS  raw asynchronous key inputs
//   key_level_o    out  KEYS  debounced state, 1 = pressed
//   key_press_o    out  KEYS  1-cycle pulse on debounced press
//   key_release_o  out  KEYS  1-cycle pulse on debounced release
//   key_repeat_o   out  KEYS  1-cycle auto-repeat pulse while held
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low: sampled on posedge clk100_i.
//   - Reset: all outputs 0, every FSM in IDLE, counters 0, sync FFs loaded with the
//     released value. Reset mid-operation aborts silently: no release pulse issued.
//   - Sync: p[k] = 2-FF synced key_i[k], inverted when ACTIVE_LOW=1 (p=1 = pressed).
//   - Per-key FSM (keys fully independent), debounce counter width $clog2(DEBOUNCE_CYC+1):
//     IDLE     : p=1 -> DB_PRESS, cnt<=0.
//     DB_PRESS : p=0 -> IDLE (bounce, no output). p=1: cnt++; when cnt==DEBOUNCE_CYC-1
//                -> HELD, key_press_o=1 for that 1 cycle, key_level_o<=1, rpt<=0.
//     HELD     : p=0 -> DB_RELEASE, cnt<=0. Else repeat timer runs (below).
//     DB_REL.  : p=1 -> HELD (level stays 1, no pulses, repeat timer restarts at 0).
//                p=0: cnt++; when cnt==DEBOUNCE_CYC-1 -> IDLE, key_release_o=1 one
//                cycle, key_level_o<=0.
//   - Latency: raw edge stable from cycle 0 -> p changes cycle 2 -> press/release pulse
//     and level change visible at cycle 2+DEBOUNCE_CYC exactly.
//   - Repeat (REPEAT_DELAY_CYC>0): rpt counts HELD cycles; first key_repeat_o when
//     rpt==REPEAT_DELAY_CYC, then every REPEAT_RATE_CYC cycles while HELD. Timer width
//     sized for max(DELAY,RATE); no wrap - reloads after each pulse. Repeat never
//     coincides with press_o; no repeat in DB_RELEASE.
//   - Press, release and repeat are mutually exclusive per key per cycle; outputs are
//     registered (no combinational path from key_i).
//   - Debounce counter saturates logically: it only counts in DB_* states, cleared on
//     every state entry, so no wrap-around is possible.
// TESTING  (bench params: DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=10, REPEAT_RATE_CYC=3,
//           ACTIVE_LOW=1, KEYS=2)
//   1 key_i[0] 1->0 at cycle 0, held -> key_press_o[0]=1 only in cycle 6; level=1 from 6.
//   2 key_i[0] low 3 cycles, high 1, low 3, high -> no press/release pulse, level stays 0.
//   3 held key, key_i[0] glitches high 2 cycles then low -> no release; clean release
//     later -> key_release_o[0]=1 exactly 6 cycles after final rising edge, level=0.
//   4 hold key 30 cycles -> press at 6, repeat pulses at 16, 19, 22, 25, 28, 31...
//     until release enters DB_RELEASE; none after.
//   5 rstn_i=0 for 1 cycle while held -> next cycle all outputs 0, no release pulse;
//     key still low after rstn_i=1 -> new press pulse 6 cycles later.
//   6 both keys pressed same cycle, key1 released 2 cycles later -> key0 press at 6,
//     key1 no pulse; per-key outputs never cross-coupled.

Source files
------------

// File: rtl/key_debounce.sv
// Per-key push-button conditioning: 2-FF sync, debounce FSM, level/press/release/auto-repeat.
// Latency 2+DEBOUNCE_CYC cycles from a stable raw edge; no backpressure, all outputs registered.
module key_debounce #(
    parameter int KEYS             = 2,
    parameter int DEBOUNCE_CYC     = 1000000,
    parameter int REPEAT_DELAY_CYC = 50000000,
    parameter int REPEAT_RATE_CYC  = 10000000,
    parameter int ACTIVE_LOW       = 1
) (
    input  logic            clk100_i,
    input  logic            rstn_i,
    input  logic [KEYS-1:0] key_i,
    output logic [KEYS-1:0] key_level_o,
    output logic [KEYS-1:0] key_press_o,
    output logic [KEYS-1:0] key_release_o,
    output logic [KEYS-1:0] key_repeat_o
);

    localparam int   CW      = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam int   RMAX    = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int   RW      = (RMAX > 1) ? $clog2(RMAX + 1) : 1;
    localparam logic REL_BIT = (ACTIVE_LOW != 0);
    localparam logic RPT_ON  = (REPEAT_DELAY_CYC > 0);

    typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

    logic [KEYS-1:0] sync1;
    logic [KEYS-1:0] sync2;
    logic [KEYS-1:0] pressed;

    // Sync FFs reset to the released level so reset never looks like a press.
    always_ff @(posedge clk100_i) begin
        if (!rstn_i) begin
            sync1 <= {KEYS{REL_BIT}};
            sync2 <= {KEYS{REL_BIT}};
        end else begin
            sync1 <= key_i;
            sync2 <= sync1;
        end
    end

    assign pressed = REL_BIT ? ~sync2 : sync2;

    for (genvar k = 0; k < KEYS; k++) begin : g_key
        state_t        state, state_nxt;
        logic [CW-1:0] cnt, cnt_nxt;
        logic [RW-1:0] rpt, rpt_nxt, rpt_inc, rpt_target;
        logic          rpt_first, rpt_first_nxt;
        logic          level, level_nxt;
        logic          press, press_nxt;
        logic          release_p, release_nxt;
        logic          repeat_p, repeat_nxt;

        always_ff @(posedge clk100_i) begin
            if (!rstn_i) begin
                state     <= IDLE;
                cnt       <= '0;
                rpt       <= '0;
                rpt_first <= 1'b0;
                level     <= 1'b0;
                press     <= 1'b0;
                release_p <= 1'b0;
                repeat_p  <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                rpt       <= rpt_nxt;
                rpt_first <= rpt_first_nxt;
                level     <= level_nxt;
                press     <= press_nxt;
                release_p <= release_nxt;
                repeat_p  <= repeat_nxt;
            end
        end

        // rpt holds completed HELD cycles; a pulse fires when this cycle reaches the target.
        assign rpt_inc    = rpt + 1'b1;
        assign rpt_target = rpt_first ? RW'(REPEAT_RATE_CYC) : RW'(REPEAT_DELAY_CYC);

        always_comb begin
            state_nxt     = state;
            cnt_nxt       = cnt;
            rpt_nxt       = rpt;
            rpt_first_nxt = rpt_first;
            level_nxt     = level;
            press_nxt     = 1'b0;
            release_nxt   = 1'b0;
            repeat_nxt    = 1'b0;
            case (state)
                IDLE: begin
                    if (pressed[k]) begin
                        state_nxt = DB_PRESS;
                        cnt_nxt   = '0;
                    end
                end
                DB_PRESS: begin
                    if (!pressed[k]) begin
                        state_nxt = IDLE;
                    end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                        state_nxt     = HELD;
                        press_nxt     = 1'b1;
                        level_nxt     = 1'b1;
                        rpt_nxt       = '0;
                        rpt_first_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!pressed[k]) begin
                        state_nxt = DB_RELEASE;
                        cnt_nxt   = '0;
                    end else if (RPT_ON) begin
                        if (rpt_inc == rpt_target) begin
                            repeat_nxt    = 1'b1;
                            rpt_nxt       = '0;
                            rpt_first_nxt = 1'b1;
                        end else begin
                            rpt_nxt = rpt_inc;
                        end
                    end
                end
                DB_RELEASE: begin
                    if (pressed[k]) begin
                        // Bounce during release: back to held, repeat restarts from the initial delay.
                        state_nxt     = HELD;
                        rpt_nxt       = '0;
                        rpt_first_nxt = 1'b0;
                    end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                        state_nxt   = IDLE;
                        release_nxt = 1'b1;
                        level_nxt   = 1'b0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        assign key_level_o[k]   = level;
        assign key_press_o[k]   = press;
        assign key_release_o[k] = release_p;
        assign key_repeat_o[k]  = repeat_p;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short debounce/repeat timings.
// Each step drives the keys for cycle n, then samples outputs #1 after posedge n.
module tb_key_debounce;

    logic       clk100_i = 1'b0;
    logic       rstn_i;
    logic [1:0] key_i;
    logic [1:0] key_level_o;
    logic [1:0] key_press_o;
    logic [1:0] key_release_o;
    logic [1:0] key_repeat_o;

    int compared   = 0;
    int mismatched = 0;

    key_debounce #(
        .KEYS(2), .DEBOUNCE_CYC(4), .REPEAT_DELAY_CYC(10),
        .REPEAT_RATE_CYC(3), .ACTIVE_LOW(1)
    ) dut (
        .clk100_i      (clk100_i),
        .rstn_i        (rstn_i),
        .key_i         (key_i),
        .key_level_o   (key_level_o),
        .key_press_o   (key_press_o),
        .key_release_o (key_release_o),
        .key_repeat_o  (key_repeat_o)
    );

    always #5 clk100_i = ~clk100_i;

    // Packed as {level, press, release, repeat}, two key bits each.
    function automatic logic [7:0] ev(int k, bit l, bit p, bit r, bit rp);
        logic [1:0] m;
        m = 2'b01 << k;
        return {l ? m : 2'b00, p ? m : 2'b00, r ? m : 2'b00, rp ? m : 2'b00};
    endfunction

    task automatic step(input string tag, input int n, input logic [7:0] exp);
        logic [7:0] obs;
        @(posedge clk100_i);
        #1;
        obs = {key_level_o, key_press_o, key_release_o, key_repeat_o};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s@%0d: observed lvl/prs/rel/rpt=%b required %b", tag, n, obs, exp);
        end
    endtask

    task automatic idle(input int cycles);
        key_i = 2'b11;
        repeat (cycles) begin
            @(posedge clk100_i);
            #1;
        end
    endtask

    initial begin
        rstn_i = 1'b0;
        key_i  = 2'b11;

        // Reset state, then idle after release of reset
        for (int n = 0; n < 3; n++) step("reset", n, 8'h00);
        rstn_i = 1'b1;
        for (int n = 0; n < 3; n++) step("idle", n, 8'h00);

        // Clean press, long hold with auto-repeat, release at cycle 30
        for (int n = 0; n <= 40; n++) begin
            key_i = {1'b1, (n >= 30)};
            step("hold", n, ev(0, (n >= 6 && n < 36), n == 6, n == 36,
                               (n >= 16 && n <= 31 && (n - 16) % 3 == 0)));
        end
        idle(4);

        // Bouncy press never reaching the debounce count
        for (int n = 0; n < 16; n++) begin
            key_i = {1'b1, !((n <= 2) || (n >= 4 && n <= 6))};
            step("bounce", n, 8'h00);
        end
        idle(4);

        // Held key with a 2-cycle high glitch, then clean release at 16
        for (int n = 0; n < 27; n++) begin
            key_i = {1'b1, !((n < 10) || (n >= 12 && n < 16))};
            step("glitch", n, ev(0, (n >= 6 && n < 22), n == 6, n == 22, 1'b0));
        end
        idle(4);

        // Synchronous reset for one cycle while held: silent abort, then re-press
        for (int n = 0; n <= 30; n++) begin
            key_i  = {1'b1, (n >= 22)};
            rstn_i = (n != 9);
            step("rst_held", n, ev(0, (n >= 6 && n <= 8) || (n >= 16 && n < 28),
                                   (n == 6) || (n == 16), n == 28, 1'b0));
        end
        rstn_i = 1'b1;
        idle(4);

        // Both keys pressed together, key1 released after 2 cycles
        for (int n = 0; n <= 20; n++) begin
            key_i = {(n >= 2), (n >= 10)};
            step("two_keys", n, ev(0, (n >= 6 && n < 16), n == 6, n == 16, 1'b0));
        end
        idle(4);

        // Key1 alone: its outputs only on bit 1
        for (int n = 0; n <= 18; n++) begin
            key_i = {(n >= 8), 1'b1};
            step("key1", n, ev(1, (n >= 6 && n < 14), n == 6, n == 14, 1'b0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
